// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared FSM states, entry control fields and index helper for the branch predictor
package bp_pkg;

   typedef enum logic {INIT, RUN} bp_state_e;

   // Per-entry control bits; tag and target widths follow the top-level
   // parameters, so those fields live in their own arrays beside this one.
   typedef struct packed {
      logic       valid;
      logic       is_jump;
      logic [1:0] ctr;
   } bp_entry_t;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

   // Word index of pc, folded with the global history in gshare mode.
   function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                            input int mode, input int idxw);
      logic [31:0] mask;
      mask = (32'd1 << idxw) - 32'd1;
      return ((pc >> 2) ^ (mode == MODE_GSHARE ? ghr : 32'd0)) & mask;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter
module sat_counter2 (
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // step toward the resolved direction, holding at either end
   always_comb ctr_o = taken_i ? (ctr_i == 2'b11 ? ctr_i : ctr_i + 2'b01)
                               : (ctr_i == 2'b00 ? ctr_i : ctr_i - 2'b01);

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with 2-bit direction counters, optional gshare indexing and table-clearing sweep
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 10,
   parameter int GHR_BITS = 6,
   parameter int MODE     = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_all,
   input  logic                lookup_valid,
   input  logic [XLEN-1:0]     pc_f,
   output logic                pred_taken,
   output logic [XLEN-1:0]     pred_target,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                upd_valid,
   input  logic [XLEN-1:0]     upd_pc,
   input  logic                upd_is_jump,
   input  logic                upd_taken,
   input  logic [XLEN-1:0]     upd_target,
   input  logic                upd_mispredict,
   input  logic [GHR_BITS-1:0] upd_ghr,
   output logic                busy,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);

   localparam int IDXW = $clog2(ENTRIES);

   typedef logic [IDXW-1:0]     idx_t;
   typedef logic [TAG_BITS-1:0] tag_t;

   bp_entry_t           meta_q [ENTRIES];
   tag_t                tag_q  [ENTRIES];
   logic [XLEN-1:0]     tgt_q  [ENTRIES];
   bp_state_e           state_q, state_d;
   idx_t                cnt_q, cnt_d;
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic [31:0]         stat_br_q, stat_mis_q;

   idx_t      lk_idx, up_idx, wr_idx;
   tag_t      lk_tag, up_tag;
   bp_entry_t lk_ent, up_ent, wr_ent;
   logic      run, lk_hit, up_hit, wr_en;
   logic [1:0] up_ctr;

   assign run    = state_q == RUN;
   assign lk_idx = idx_t'(bp_index(32'(pc_f[IDXW+1:0]), 32'(ghr_q), MODE, IDXW));
   assign up_idx = idx_t'(bp_index(32'(upd_pc[IDXW+1:0]), 32'(upd_ghr), MODE, IDXW));
   assign lk_tag = pc_f[TAG_BITS+IDXW+1 -: TAG_BITS];
   assign up_tag = upd_pc[TAG_BITS+IDXW+1 -: TAG_BITS];
   assign lk_ent = meta_q[lk_idx];
   assign up_ent = meta_q[up_idx];
   assign lk_hit = lookup_valid & lk_ent.valid & (tag_q[lk_idx] == lk_tag) & run;
   assign up_hit = up_ent.valid & (tag_q[up_idx] == up_tag);

   assign pred_taken       = lk_hit & (lk_ent.is_jump | lk_ent.ctr[1]);
   assign pred_target      = pred_taken ? tgt_q[lk_idx] : pc_f + XLEN'(4);
   assign pred_ghr         = ghr_q;
   assign busy             = !run;
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mis_q;

   sat_counter2 u_sat (
      .ctr_i   (up_ent.ctr),
      .taken_i (upd_taken),
      .ctr_o   (up_ctr)
   );

   // sweep sequencing, history speculation/repair and selection of the single table write
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ghr_d   = ghr_q;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
      wr_ent  = '{valid: 1'b0, is_jump: 1'b0, ctr: 2'b01};
      if (flush_all) begin
         state_d = INIT;
         cnt_d   = '0;
         ghr_d   = '0;
      end else if (!run) begin
         wr_en   = 1'b1;
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == idx_t'(ENTRIES - 1) ? RUN : INIT;
      end else begin
         if (lk_hit & !lk_ent.is_jump) ghr_d = GHR_BITS'({ghr_q, lk_ent.ctr[1]});
         if (upd_valid & upd_mispredict) ghr_d = upd_is_jump ? upd_ghr : GHR_BITS'({upd_ghr, upd_taken});
         wr_en  = upd_valid & (up_hit | upd_taken | upd_is_jump);
         wr_idx = up_idx;
         wr_ent = '{valid: 1'b1, is_jump: upd_is_jump, ctr: up_hit ? up_ctr : 2'b10};
      end
   end

   // control state, history and saturating statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         ghr_q      <= '0;
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ghr_q   <= ghr_d;
         if (upd_valid && stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
         if (upd_valid && upd_mispredict && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   // table write port; entries carry no reset because the sweep clears them
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         meta_q[wr_idx] <= wr_ent;
         tag_q[wr_idx]  <= up_tag;
         tgt_q[wr_idx]  <= upd_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: bimodal and gshare instances checked against a behavioural table model
module tb_branch_predictor;

   localparam int E = 64;

   logic        clk = 0, reset = 1, flush_all = 0, lookup_valid = 0;
   logic [31:0] pc_f = 0, upd_pc = 0, upd_target = 0;
   logic        upd_valid = 0, upd_is_jump = 0, upd_taken = 0, upd_mispredict = 0;
   logic [5:0]  upd_ghr = 0;
   logic        pt [2];
   logic [31:0] ptg [2];
   logic [5:0]  pg [2];
   logic        bsy [2];
   logic [31:0] sb [2], sm [2];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   branch_predictor #(.MODE(0)) u0 (
      .clk(clk), .reset(reset), .flush_all(flush_all), .lookup_valid(lookup_valid), .pc_f(pc_f),
      .pred_taken(pt[0]), .pred_target(ptg[0]), .pred_ghr(pg[0]),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
      .busy(bsy[0]), .stat_branches(sb[0]), .stat_mispredicts(sm[0])
   );

   branch_predictor #(.MODE(1)) u1 (
      .clk(clk), .reset(reset), .flush_all(flush_all), .lookup_valid(lookup_valid), .pc_f(pc_f),
      .pred_taken(pt[1]), .pred_target(ptg[1]), .pred_ghr(pg[1]),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
      .busy(bsy[1]), .stat_branches(sb[1]), .stat_mispredicts(sm[1])
   );

   // reference model: index 0 = bimodal instance, 1 = gshare instance
   bit          mv   [2][E];
   int          mtag [2][E];
   logic [31:0] mtgt [2][E];
   bit          mj   [2][E];
   int          mc   [2][E];
   int          mg [2];
   int          left [2];
   logic [31:0] mbr [2], mmis [2];

   function automatic int midx(int m, logic [31:0] pc, int g);
      int i;
      i = int'((pc >> 2) & 32'h3f);
      return m == 1 ? (i ^ g) : i;
   endfunction

   function automatic int mtagf(logic [31:0] pc);
      return int'((pc >> 8) & 32'h3ff);
   endfunction

   function automatic bit mhit(int m);
      int i;
      i = midx(m, pc_f, mg[m]);
      return lookup_valid && left[m] == 0 && mv[m][i] && mtag[m][i] == mtagf(pc_f);
   endfunction

   function automatic bit exp_taken(int m);
      int i;
      i = midx(m, pc_f, mg[m]);
      return mhit(m) && (mj[m][i] || mc[m][i] >= 2);
   endfunction

   function automatic logic [31:0] exp_tgt(int m);
      return exp_taken(m) ? mtgt[m][midx(m, pc_f, mg[m])] : pc_f + 32'd4;
   endfunction

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            left[m] = E;
            mg[m]   = 0;
            mbr[m]  = 0;
            mmis[m] = 0;
            for (int k = 0; k < E; k++) mv[m][k] = 0;
         end else begin
            if (upd_valid && mbr[m] != 32'hFFFF_FFFF) mbr[m]++;
            if (upd_valid && upd_mispredict && mmis[m] != 32'hFFFF_FFFF) mmis[m]++;
            if (flush_all) begin
               left[m] = E;
               mg[m]   = 0;
               for (int k = 0; k < E; k++) mv[m][k] = 0;
            end else if (left[m] > 0) begin
               left[m]--;
            end else begin
               int g, li, ui;
               g  = mg[m];
               li = midx(m, pc_f, mg[m]);
               ui = midx(m, upd_pc, int'(upd_ghr));
               if (mhit(m) && !mj[m][li]) g = (g * 2 + (mc[m][li] >= 2 ? 1 : 0)) % 64;
               if (upd_valid && upd_mispredict)
                  g = upd_is_jump ? int'(upd_ghr) : (int'(upd_ghr) * 2 + int'(upd_taken)) % 64;
               if (upd_valid) begin
                  if (mv[m][ui] && mtag[m][ui] == mtagf(upd_pc)) begin
                     mc[m][ui]   = upd_taken ? (mc[m][ui] < 3 ? mc[m][ui] + 1 : 3)
                                             : (mc[m][ui] > 0 ? mc[m][ui] - 1 : 0);
                     mtgt[m][ui] = upd_target;
                     mj[m][ui]   = upd_is_jump;
                  end else if (upd_taken || upd_is_jump) begin
                     mv[m][ui]   = 1;
                     mtag[m][ui] = mtagf(upd_pc);
                     mtgt[m][ui] = upd_target;
                     mj[m][ui]   = upd_is_jump;
                     mc[m][ui]   = 2;
                  end
               end
               mg[m] = g;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0;
      flush_all = 0;
      lookup_valid = 0;
      upd_valid = 0;
      upd_mispredict = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input bit jump, input bit taken, input logic [31:0] tgt,
                      input bit mis, input logic [5:0] ghr);
      upd_valid = 1;
      upd_pc = pc;
      upd_is_jump = jump;
      upd_taken = taken;
      upd_target = tgt;
      upd_mispredict = mis;
      upd_ghr = ghr;
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_valid = 1;
      pc_f = pc;
   endtask

   task automatic test_reset();
      int nb;
      reset = 1;
      tick();
      tick();
      idle();
      #2;
      for (int m = 0; m < 2; m++) begin
         n_chk++; if (bsy[m] !== 1'b1) $display("FAIL reset_busy[%0d] got %0b want 1", m, bsy[m]); else n_pass++;
         n_chk++; if (sb[m] !== 32'd0) $display("FAIL reset_branches[%0d] got %0h want 0", m, sb[m]); else n_pass++;
         n_chk++; if (sm[m] !== 32'd0) $display("FAIL reset_mispredicts[%0d] got %0h want 0", m, sm[m]); else n_pass++;
         n_chk++; if (pg[m] !== 6'd0) $display("FAIL reset_ghr[%0d] got %0h want 0", m, pg[m]); else n_pass++;
      end
      nb = 0;
      for (int c = 0; c < 200 && bsy[0]; c++) begin
         look($urandom & 32'hFFFF_FFFC);
         upd($urandom, 1, 1, $urandom, 1, 6'($urandom));
         #2;
         nb++;
         n_chk++; if (pt[0] !== 1'b0 || pt[1] !== 1'b0) $display("FAIL sweep_taken got %0b/%0b want 0", pt[0], pt[1]); else n_pass++;
         n_chk++; if (ptg[1] !== pc_f + 32'd4) $display("FAIL sweep_target got %0h want %0h", ptg[1], pc_f + 32'd4); else n_pass++;
         tick();
      end
      idle();
      #2;
      n_chk++; if (nb != 64) $display("FAIL busy_cycles got %0d want 64", nb); else n_pass++;
      n_chk++; if (bsy[1] !== 1'b0) $display("FAIL busy_end got %0b want 0", bsy[1]); else n_pass++;
   endtask

   task automatic test_bimodal();
      upd(32'h1000_0040, 0, 1, 32'h1000_0100, 1, 6'd0);
      tick();
      idle();
      look(32'h1000_0040);
      #2;
      n_chk++; if (pt[0] !== 1'b1) $display("FAIL bimodal_taken got %0b want 1", pt[0]); else n_pass++;
      n_chk++; if (ptg[0] !== 32'h1000_0100) $display("FAIL bimodal_target got %0h want 10000100", ptg[0]); else n_pass++;
      n_chk++; if (pt[1] !== exp_taken(1)) $display("FAIL gshare_model_taken got %0b want %0b", pt[1], exp_taken(1)); else n_pass++;
      tick();
      idle();
      upd(32'h1000_0040, 0, 0, 32'h1000_0100, 1, 6'd0);
      tick();
      tick();
      idle();
      look(32'h1000_0040);
      #2;
      n_chk++; if (pt[0] !== 1'b0) $display("FAIL bimodal_untrained got %0b want 0", pt[0]); else n_pass++;
      n_chk++; if (ptg[0] !== 32'h1000_0044) $display("FAIL bimodal_fallthrough got %0h want 10000044", ptg[0]); else n_pass++;
      tick();
   endtask

   task automatic test_no_alloc();
      idle();
      upd(32'h1000_0080, 0, 0, 32'h1234_5678, 0, 6'd0);
      tick();
      idle();
      look(32'h1000_0080);
      #2;
      n_chk++; if (pt[0] !== 1'b0) $display("FAIL no_alloc_taken got %0b want 0", pt[0]); else n_pass++;
      n_chk++; if (ptg[0] !== 32'h1000_0084) $display("FAIL no_alloc_target got %0h want 10000084", ptg[0]); else n_pass++;
      tick();
   endtask

   task automatic test_gshare_ghr();
      idle();
      upd(32'h3000_0020, 0, 1, 32'h3000_0400, 0, 6'b000101);
      tick();
      tick();
      upd(32'h3000_0900, 0, 1, 32'h3000_0a00, 1, 6'b000010);
      tick();
      idle();
      look(32'h3000_0020);
      #2;
      n_chk++; if (pg[1] !== 6'b000101) $display("FAIL gshare_pred_ghr got %b want 000101", pg[1]); else n_pass++;
      n_chk++; if (pt[1] !== 1'b1) $display("FAIL gshare_taken got %0b want 1", pt[1]); else n_pass++;
      n_chk++; if (ptg[1] !== 32'h3000_0400) $display("FAIL gshare_target got %0h want 30000400", ptg[1]); else n_pass++;
      tick();
      idle();
      #2;
      n_chk++; if (pg[1] !== 6'b001011) $display("FAIL gshare_shift got %b want 001011", pg[1]); else n_pass++;
      upd(32'h3000_0900, 0, 1, 32'h3000_0a00, 1, 6'b000010);
      tick();
      idle();
      look(32'h3000_0020);
      upd(32'h3000_0b00, 0, 0, 32'h0, 1, 6'b000000);
      #2;
      n_chk++; if (pt[1] !== 1'b1) $display("FAIL repair_hit got %0b want 1", pt[1]); else n_pass++;
      tick();
      idle();
      #2;
      n_chk++; if (pg[1] !== 6'b000000) $display("FAIL repair_wins got %b want 000000", pg[1]); else n_pass++;
   endtask

   task automatic test_alias();
      idle();
      upd(32'h2000_0010, 1, 1, 32'h2000_0800, 1, 6'd0);
      tick();
      idle();
      look(32'h2000_0010);
      #2;
      n_chk++; if (pt[0] !== 1'b1 || ptg[0] !== 32'h2000_0800) $display("FAIL alias_first got %0b/%0h want 1/20000800", pt[0], ptg[0]); else n_pass++;
      tick();
      idle();
      upd(32'h2000_0110, 1, 1, 32'h2000_0900, 1, 6'd0);
      tick();
      idle();
      look(32'h2000_0010);
      #2;
      n_chk++; if (pt[0] !== 1'b0 || ptg[0] !== 32'h2000_0014) $display("FAIL alias_evicted got %0b/%0h want 0/20000014", pt[0], ptg[0]); else n_pass++;
      tick();
      look(32'h2000_0110);
      #2;
      n_chk++; if (pt[0] !== 1'b1 || ptg[0] !== 32'h2000_0900) $display("FAIL alias_second got %0b/%0h want 1/20000900", pt[0], ptg[0]); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         idle();
         flush_all = ($urandom_range(0, 199) == 0);
         lookup_valid = $urandom_range(0, 1);
         pc_f = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 8);
         upd_valid = $urandom_range(0, 1);
         upd_pc = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 8);
         upd_is_jump = ($urandom_range(0, 3) == 0);
         upd_taken = upd_is_jump | 1'($urandom_range(0, 1));
         upd_target = $urandom & 32'hFFFF_FFFC;
         upd_mispredict = $urandom_range(0, 1);
         upd_ghr = 6'($urandom);
         #2;
         for (int m = 0; m < 2; m++) begin
            n_chk++; if (pt[m] !== exp_taken(m)) $display("FAIL rand_taken[%0d] got %0b want %0b", m, pt[m], exp_taken(m)); else n_pass++;
            n_chk++; if (ptg[m] !== exp_tgt(m)) $display("FAIL rand_target[%0d] got %0h want %0h", m, ptg[m], exp_tgt(m)); else n_pass++;
            n_chk++; if (pg[m] !== 6'(mg[m])) $display("FAIL rand_ghr[%0d] got %0h want %0h", m, pg[m], mg[m]); else n_pass++;
            n_chk++; if (bsy[m] !== (left[m] > 0)) $display("FAIL rand_busy[%0d] got %0b want %0b", m, bsy[m], left[m] > 0); else n_pass++;
            n_chk++; if (sb[m] !== mbr[m] || sm[m] !== mmis[m]) $display("FAIL rand_stats[%0d] got %0h/%0h want %0h/%0h", m, sb[m], sm[m], mbr[m], mmis[m]); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_stats();
      int nb;
      idle();
      tick();
      force u0.stat_mis_q = 32'hFFFF_FFFE;
      mmis[0] = 32'hFFFF_FFFE;
      #1;
      release u0.stat_mis_q;
      upd(32'h5000_0000, 0, 1, 32'h5000_0100, 1, 6'd0);
      tick();
      #2;
      n_chk++; if (sm[0] !== 32'hFFFF_FFFF) $display("FAIL stat_reach_max got %0h want ffffffff", sm[0]); else n_pass++;
      tick();
      tick();
      idle();
      #2;
      n_chk++; if (sm[0] !== 32'hFFFF_FFFF) $display("FAIL stat_saturate got %0h want ffffffff", sm[0]); else n_pass++;
      n_chk++; if (sm[1] !== mmis[1] || sb[0] !== mbr[0]) $display("FAIL stat_other got %0h/%0h want %0h/%0h", sm[1], sb[0], mmis[1], mbr[0]); else n_pass++;
      flush_all = 1;
      tick();
      idle();
      nb = 0;
      for (int c = 0; c < 200 && bsy[0]; c++) begin
         #2;
         nb++;
         tick();
      end
      #2;
      n_chk++; if (nb != 64) $display("FAIL flush_busy_cycles got %0d want 64", nb); else n_pass++;
      n_chk++; if (sm[0] !== 32'hFFFF_FFFF || sb[1] !== mbr[1]) $display("FAIL flush_stats_kept got %0h/%0h want ffffffff/%0h", sm[0], sb[1], mbr[1]); else n_pass++;
      flush_all = 1;
      tick();
      idle();
      for (int c = 0; c < 10; c++) tick();
      reset = 1;
      tick();
      idle();
      nb = 0;
      for (int c = 0; c < 200 && bsy[1]; c++) begin
         #2;
         nb++;
         tick();
      end
      #2;
      n_chk++; if (nb != 64) $display("FAIL midsweep_reset_busy got %0d want 64", nb); else n_pass++;
      n_chk++; if (sm[0] !== 32'd0 || sb[0] !== 32'd0) $display("FAIL midsweep_reset_stats got %0h/%0h want 0/0", sm[0], sb[0]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bimodal();
      test_no_alloc();
      test_gshare_ghr();
      test_alias();
      test_random();
      test_stats();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
